// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding, grant IDs and default widths/timeout.
package riscv_mem_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // Grant IDs, also the encoding of the last_grant register
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory latency watchdog. Counts busy cycles without mem_ready and flags
// expiry on the cycle that would make the count reach TIMEOUT, so a ready
// arriving in that same cycle (enable low) still wins over the abort.
module mem_arb_watchdog
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == LAST);

    // Next count: clear on request, on expiry, otherwise count stalled cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-ported memory between instruction
// fetch and data access. One transaction at a time; each requester gets a
// one-cycle ack with read data, and a watchdog aborts stalled transactions.
//
// Handshake: x_req is held until the cycle x_ack is high and must be dropped
// in that cycle; mem_req is held until mem_ready is sampled high (or the
// watchdog aborts). Arbitration happens only in IDLE, which includes the ack
// cycle, so back-to-back transactions have one cycle of mem_req=0 between.
//
// Build option: define UNIFIED_MEM_ARB_RR_EN for round-robin on conflicts;
// undefined gives fixed data-over-fetch priority.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic [1:0]        dbg_state
);

    arb_state_e        state_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
`ifdef UNIFIED_MEM_ARB_RR_EN
    logic              last_grant_q;
`endif

    logic busy;
    logic wd_expired;
    logic grant_dm;

    assign busy = (state_q != IDLE);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!busy || mem_ready),
        .enable_i  (busy && !mem_ready),
        .expired_o (wd_expired)
    );

    // Arbitration: data wins by default; with round-robin a conflict goes to
    // the requester that was not served last
    always_comb begin
        grant_dm = dm_req;
`ifdef UNIFIED_MEM_ARB_RR_EN
        if (dm_req && if_req) begin
            grant_dm = (last_grant_q == GNT_IF);
        end
`endif
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef UNIFIED_MEM_ARB_RR_EN
            last_grant_q <= GNT_IF;
`endif
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (if_req) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // Ready beats a same-cycle watchdog expiry
                    if (mem_ready || wd_expired) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        err_q       <= !mem_ready;
                        if (state_q == BUSY_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_ready ? mem_rdata : '0;
                        end else begin
                            dm_ack_q   <= 1'b1;
                            dm_rdata_q <= mem_ready ? mem_rdata : '0;
                        end
`ifdef UNIFIED_MEM_ARB_RR_EN
                        last_grant_q <= (state_q == BUSY_IF) ? GNT_IF : GNT_DM;
`endif
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. A main instance uses the default
// TIMEOUT; a second instance with TIMEOUT=4 exercises the watchdog.
// Expectations follow UNIFIED_MEM_ARB_RR_EN when it is defined.
module tb_unified_mem_arbiter;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, err;
    logic [1:0]  dbg_state;

    unified_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- watchdog instance ----------------
    logic        w_if_req = 0, w_dm_req = 0, w_dm_we = 0, w_mem_ready = 0;
    logic [31:0] w_if_addr = 0, w_dm_addr = 0, w_dm_wdata = 0, w_mem_rdata = 0;
    logic [31:0] w_if_rdata, w_dm_rdata, w_mem_addr, w_mem_wdata;
    logic        w_if_ack, w_dm_ack, w_mem_req, w_mem_we, w_err;
    logic [1:0]  w_dbg_state;

    unified_mem_arbiter #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .reset(reset),
        .if_req(w_if_req), .if_addr(w_if_addr), .if_rdata(w_if_rdata), .if_ack(w_if_ack),
        .dm_req(w_dm_req), .dm_we(w_dm_we), .dm_addr(w_dm_addr), .dm_wdata(w_dm_wdata),
        .dm_rdata(w_dm_rdata), .dm_ack(w_dm_ack),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_rdata(w_mem_rdata), .mem_ready(w_mem_ready), .err(w_err), .dbg_state(w_dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first mem_req cycle: raises mem_ready 'delay' cycles
    // later and returns in the ack cycle
    task automatic mem_respond(input int delay, input logic [31:0] data,
                               output int held, output logic any_ack);
        held    = 0;
        any_ack = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (mem_req) held++;
            if (if_ack || dm_ack) any_ack = 1'b1;
            if (i == delay) begin
                mem_ready = 1'b1;
                mem_rdata = data;
            end
            tick();
            mem_ready = 1'b0;
            mem_rdata = '0;
        end
    endtask

    int   held;
    int   busy_cnt;
    logic any_ack;
    logic exp_dm;

    initial begin
        // ---- reset state ----
        tick();
        tick();
        check_eq("rst_state", dbg_state, S_IDLE);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_acks", {if_ack, dm_ack, err}, 3'b000);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        tick();

        // ---- single fetch, ready one cycle after mem_req ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        tick();
        check_eq("f1_mem_req", mem_req, 1'b1);
        check_eq("f1_mem_addr", mem_addr, 32'h40);
        check_eq("f1_mem_we", mem_we, 1'b0);
        check_eq("f1_state", dbg_state, S_BUSY_IF);
        mem_respond(1, 32'h0010_0093, held, any_ack);
        check_eq("f1_held", held, 2);
        check_eq("f1_no_early_ack", any_ack, 1'b0);
        check_eq("f1_if_ack", if_ack, 1'b1);
        check_eq("f1_if_rdata", if_rdata, 32'h0010_0093);
        check_eq("f1_mem_clr", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
        check_eq("f1_err", err, 1'b0);
        if_req = 1'b0;
        tick();
        check_eq("f1_ack_pulse", if_ack, 1'b0);
        check_eq("f1_no_reissue", mem_req, 1'b0);

        // ---- simultaneous store and fetch: store first ----
        if_req   = 1'b1;
        if_addr  = 32'h0000_0044;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("c_dm_state", dbg_state, S_BUSY_DM);
        check_eq("c_dm_we", mem_we, 1'b1);
        check_eq("c_dm_addr", mem_addr, 32'h100);
        check_eq("c_dm_wdata", mem_wdata, 32'hDEAD_BEEF);
        dm_wdata = 32'h1111_1111;  // changes while busy must be ignored
        mem_respond(0, 32'h0BAD_F00D, held, any_ack);
        check_eq("c_dm_ack", {dm_ack, if_ack}, 2'b10);
        check_eq("c_gap", mem_req, 1'b0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        check_eq("c_if_state", dbg_state, S_BUSY_IF);
        check_eq("c_if_addr", mem_addr, 32'h44);
        check_eq("c_if_we", mem_we, 1'b0);
        mem_respond(1, 32'hCAFE_0001, held, any_ack);
        check_eq("c_if_ack", {dm_ack, if_ack}, 2'b01);
        check_eq("c_if_rdata", if_rdata, 32'hCAFE_0001);
        if_req = 1'b0;
        tick();

        // ---- load with 5-cycle memory latency ----
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0200;
        tick();
        check_eq("l_addr", mem_addr, 32'h200);
        check_eq("l_we", mem_we, 1'b0);
        mem_respond(5, 32'h1234_5678, held, any_ack);
        check_eq("l_held", held, 6);
        check_eq("l_no_early_ack", any_ack, 1'b0);
        check_eq("l_acks", {dm_ack, if_ack}, 2'b10);
        check_eq("l_rdata", dm_rdata, 32'h1234_5678);
        dm_req = 1'b0;
        tick();

        // ---- watchdog, TIMEOUT=4: ready on 4th busy cycle wins ----
        w_dm_req  = 1'b1;
        w_dm_addr = 32'h0000_0300;
        tick();
        tick();
        tick();
        tick();
        check_eq("wd_still_busy", w_mem_req, 1'b1);
        w_mem_ready = 1'b1;
        w_mem_rdata = 32'hA5A5_0004;
        tick();
        w_mem_ready = 1'b0;
        w_mem_rdata = '0;
        check_eq("wd_ok_ack", w_dm_ack, 1'b1);
        check_eq("wd_ok_err", w_err, 1'b0);
        check_eq("wd_ok_rdata", w_dm_rdata, 32'hA5A5_0004);
        w_dm_req = 1'b0;
        tick();

        // ---- watchdog abort with mem_ready held low ----
        w_dm_req = 1'b1;
        tick();
        busy_cnt = 0;
        while (w_mem_req && busy_cnt < 20) begin
            busy_cnt++;
            tick();
        end
        check_eq("wd_busy_cycles", busy_cnt, 4);
        check_eq("wd_abort_err", w_err, 1'b1);
        check_eq("wd_abort_ack", w_dm_ack, 1'b1);
        check_eq("wd_abort_rdata", w_dm_rdata, 32'h0);
        check_eq("wd_abort_state", w_dbg_state, S_IDLE);
        w_dm_req = 1'b0;
        tick();
        check_eq("wd_err_pulse", {w_err, w_dm_ack}, 2'b00);

        // ---- reset during BUSY_DM ----
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0500;
        tick();
        tick();
        tick();
        check_eq("r_busy", dbg_state, S_BUSY_DM);
        reset = 1'b0;
        tick();
        check_eq("r_state", dbg_state, S_IDLE);
        check_eq("r_mem_req", mem_req, 1'b0);
        check_eq("r_no_ack_err", {dm_ack, err}, 2'b00);
        reset  = 1'b1;
        dm_req = 1'b0;
        tick();
        check_eq("r_quiet", {dm_ack, err, mem_req}, 3'b000);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        tick();
        check_eq("r_if_addr", mem_addr, 32'h80);
        mem_respond(2, 32'h0000_0013, held, any_ack);
        check_eq("r_if_ack", if_ack, 1'b1);
        check_eq("r_if_rdata", if_rdata, 32'h13);
        if_req = 1'b0;
        tick();

        // ---- both requesters held for 8 transactions ----
        if_req  = 1'b1;
        if_addr = 32'h0000_1000;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_2000;
        for (int i = 0; i < 8; i++) begin
`ifdef UNIFIED_MEM_ARB_RR_EN
            exp_dm = (i % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            tick();
            check_eq($sformatf("h%0d_state", i), dbg_state, exp_dm ? S_BUSY_DM : S_BUSY_IF);
            check_eq($sformatf("h%0d_addr", i), mem_addr, exp_dm ? 32'h2000 : 32'h1000);
            mem_respond(0, 32'h100 + i, held, any_ack);
            check_eq($sformatf("h%0d_acks", i), {dm_ack, if_ack}, {exp_dm, !exp_dm});
            if (i == 7) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        tick();
        check_eq("h_end_idle", mem_req, 1'b0);

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
